gray_counter_param: RTL and testbench

Parametrised, registered Gray-code counter. It generalises the fixed 3-bit up-counter with sticky overflow to WIDTH bits, and adds up/down direction, a synchronous parallel load, a wrap/saturate mode, a clearable sticky overflow flag and a one-cycle wrap pulse. It is used as a standalone P0 component and as the pointer/sequence source for later clock-domain-crossing blocks.

---
 rtl/gray_pkg.sv | 30 +++
 rtl/gray2bin_conv.sv | 20 ++
 rtl/gray_counter_param.sv | 100 ++++++++++
 tb/tb_gray_counter_param.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code counter family: direction/mode encodings
// and width-generic Gray/binary conversion helpers.
package gray_pkg;

  // Helpers work on a fixed wide word; callers zero-extend and truncate. Leading
  // zeros do not disturb either conversion, so any WIDTH up to MAX_WIDTH is exact.
  localparam int unsigned MAX_WIDTH = 32;

  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  typedef logic [MAX_WIDTH-1:0] word_t;

  function automatic word_t bin2gray(input word_t b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above its position.
  function automatic word_t gray2bin(input word_t g);
    word_t b;
    b = '0;
    for (int i = 0; i < int'(MAX_WIDTH); i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
module gray2bin_conv
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Bit i is the reduction XOR of gray[WIDTH-1:i]; no bit depends on another
  // output bit, which keeps the network free of internal feedback.
  always_comb begin
    bin = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/gray_counter_param.sv
// Parametrised registered Gray-code counter with up/down, parallel load,
// wrap/saturate mode, clearable sticky overflow and a one-cycle wrap pulse.
module gray_counter_param
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned INIT  = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Dir,
  input  logic             Mode,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             ClrOvf,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] BinOut,
  output logic             Overflow,
  output logic             Wrap
);

  localparam logic [WIDTH-1:0] InitBin = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] InitGry = WIDTH'(bin2gray(word_t'(INIT)));
  localparam logic [WIDTH-1:0] MaxBin  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] OneBin  = WIDTH'(1);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gry_q, gry_d;
  logic             ovf_q, ovf_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] step_bin;
  logic             at_bound;
  logic             bound_evt;

  gray2bin_conv #(
    .WIDTH (WIDTH)
  ) u_load_conv (
    .gray (LoadVal),
    .bin  (load_bin)
  );

  // Next-state selection: Load beats En; a step at the active bound is the
  // only source of overflow/wrap. Modulo arithmetic already wraps correctly.
  always_comb begin
    at_bound  = (Dir == DIR_UP) ? (bin_q == MaxBin) : (bin_q == '0);
    step_bin  = (Dir == DIR_UP) ? (bin_q + OneBin) : (bin_q - OneBin);
    bound_evt = 1'b0;
    bin_d     = bin_q;
    gry_d     = gry_q;

    if (Load) begin
      bin_d = load_bin;
      gry_d = LoadVal;
    end else if (En) begin
      bound_evt = at_bound;
      if (at_bound && (Mode == MODE_SAT)) begin
        bin_d = bin_q;
      end else begin
        bin_d = step_bin;
      end
      gry_d = WIDTH'(bin2gray(word_t'(bin_d)));
    end

    // A boundary event in the same cycle overrides a clear request.
    ovf_d  = bound_evt | (ovf_q & ~ClrOvf);
    wrap_d = bound_evt;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      bin_q  <= InitBin;
      gry_q  <= InitGry;
      ovf_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gry_q  <= gry_d;
      ovf_q  <= ovf_d;
      wrap_q <= wrap_d;
    end
  end

  assign Output   = gry_q;
  assign BinOut   = bin_q;
  assign Overflow = ovf_q;
  assign Wrap     = wrap_q;

  // The Gray register must always mirror the binary register.
  a_gray_consistent : assert property (@(posedge Clk) disable iff (!Reset)
    gry_q == WIDTH'(bin2gray(word_t'(bin_q))));

  // Counting (no reset, no load on the previous edge) changes at most one bit.
  a_single_bit_step : assert property (@(posedge Clk)
    (Reset && $past(Reset) && !$past(Load)) |-> ($countones(gry_q ^ $past(gry_q)) <= 1));

endmodule

// File: tb/tb_gray_counter_param.sv
// Self-checking bench for gray_counter_param (WIDTH = 3, INIT = 0).
module tb_gray_counter_param;

  localparam int W = 3;

  logic         Clk = 1'b0;
  logic         Reset = 1'b0;
  logic         En = 1'b0;
  logic         Dir = 1'b0;
  logic         Mode = 1'b0;
  logic         Load = 1'b0;
  logic [W-1:0] LoadVal = '0;
  logic         ClrOvf = 1'b0;
  logic [W-1:0] Output;
  logic [W-1:0] BinOut;
  logic         Overflow;
  logic         Wrap;

  int checks = 0;
  int errors = 0;

  // Reference model: count position as an integer, Gray code from a table.
  logic [W-1:0] gray_seq [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                                 3'b110, 3'b111, 3'b101, 3'b100};
  int   m_pos   = 0;
  logic m_ovf   = 1'b0;
  logic m_wrap  = 1'b0;
  logic m_valid = 1'b0;

  gray_counter_param #(
    .WIDTH (W),
    .INIT  (0)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .En       (En),
    .Dir      (Dir),
    .Mode     (Mode),
    .Load     (Load),
    .LoadVal  (LoadVal),
    .ClrOvf   (ClrOvf),
    .Output   (Output),
    .BinOut   (BinOut),
    .Overflow (Overflow),
    .Wrap     (Wrap)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int gray_index(input logic [W-1:0] g);
    for (int i = 0; i < 8; i++) begin
      if (gray_seq[i] == g) return i;
    end
    return -1;
  endfunction

  // Advance the model by one edge using the inputs that were just sampled.
  task automatic model_edge();
    bit hit;
    if (!Reset) begin
      m_pos = 0; m_ovf = 1'b0; m_wrap = 1'b0;
    end else if (Load) begin
      m_pos = gray_index(LoadVal);
      m_ovf = m_ovf & ~ClrOvf; m_wrap = 1'b0;
    end else if (En) begin
      hit = Dir ? (m_pos == 0) : (m_pos == 7);
      if (hit) begin
        if (!Mode) m_pos = Dir ? 7 : 0;
        m_ovf = 1'b1; m_wrap = 1'b1;
      end else begin
        m_pos = Dir ? m_pos - 1 : m_pos + 1;
        m_ovf = m_ovf & ~ClrOvf; m_wrap = 1'b0;
      end
    end else begin
      m_ovf = m_ovf & ~ClrOvf; m_wrap = 1'b0;
    end
    m_valid = 1'b1;
  endtask

  // Apply one set of inputs across one rising edge; returns at the next falling edge.
  task automatic step(input logic rst_n, input logic en, input logic dir, input logic mode,
                      input logic ld, input logic [W-1:0] lv, input logic clr);
    Reset = rst_n; En = en; Dir = dir; Mode = mode;
    Load = ld; LoadVal = lv; ClrOvf = clr;
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    if (m_valid) begin
      check("model_output", int'(Output), int'(gray_seq[m_pos]));
      check("model_binout", int'(BinOut), m_pos);
      check("model_overflow", int'(Overflow), int'(m_ovf));
      check("model_wrap", int'(Wrap), int'(m_wrap));
    end
  end

  logic [W-1:0] up_seq [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                               3'b110, 3'b111, 3'b101, 3'b100};

  initial begin
    // Reset state.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    check("reset_output", int'(Output), 0);
    check("reset_binout", int'(BinOut), 0);
    check("reset_overflow", int'(Overflow), 0);
    check("reset_wrap", int'(Wrap), 0);

    // Up count through the full sequence, then wrap to 000.
    for (int i = 1; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
      check("up_seq", int'(Output), int'(up_seq[i]));
      check("up_no_wrap", int'(Wrap), 0);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    check("up_wrap_output", int'(Output), 0);
    check("up_wrap_pulse", int'(Wrap), 1);
    check("up_wrap_ovf", int'(Overflow), 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    check("wrap_one_cycle", int'(Wrap), 0);
    check("ovf_sticky", int'(Overflow), 1);

    // Down from reset: immediate wrap to 7.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    check("down_wrap_output", int'(Output), 3'b100);
    check("down_wrap_binout", int'(BinOut), 7);
    check("down_wrap_ovf", int'(Overflow), 1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    check("down_step1", int'(Output), 3'b101);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    check("down_step2", int'(Output), 3'b111);

    // Saturate at the top bound.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b100, 1'b1);
    check("load_top_ovf_clr", int'(Overflow), 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
      check("sat_output", int'(Output), 3'b100);
      check("sat_wrap", int'(Wrap), 1);
      check("sat_ovf", int'(Overflow), 1);
    end

    // Load beats En; next En step goes from 4 to 5.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b110, 1'b0);
    check("load_binout", int'(BinOut), 4);
    check("load_output", int'(Output), 3'b110);
    check("load_wrap", int'(Wrap), 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    check("after_load_step", int'(Output), 3'b111);

    // ClrOvf without event clears; on a wrap edge the event wins.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
    check("clr_no_event", int'(Overflow), 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b100, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
    check("clr_on_wrap_ovf", int'(Overflow), 1);
    check("clr_on_wrap_output", int'(Output), 0);

    // Reset mid-count overrides Load and En.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    check("pre_reset_output", int'(Output), 3'b011);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b111, 1'b1);
    check("midreset_output", int'(Output), 0);
    check("midreset_binout", int'(BinOut), 0);
    check("midreset_ovf", int'(Overflow), 0);
    check("midreset_wrap", int'(Wrap), 0);

    // Mixed direction/mode/load/clear traffic checked by the model.
    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 15) != 0), $urandom_range(0, 3) != 0,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 5) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
